// File: rtl/np_pkg.sv
// Shared constants and state encodings for the NinPortable boot/IO block.
package np_pkg;

    // SPI flash opcodes
    localparam logic [7:0] OP_WAKE = 8'hAB;   // release from deep power-down
    localparam logic [7:0] OP_READ = 8'h03;   // plain read, 24-bit address

    // UART framing: 8N1
    localparam int UART_DATA_BITS  = 8;
    localparam int UART_STOP_BITS  = 1;
    localparam int UART_FRAME_BITS = 1 + UART_DATA_BITS + UART_STOP_BITS;

    typedef enum logic [2:0] {
        WAKE      = 3'd0,
        GAP1      = 3'd1,
        READ_CMD  = 3'd2,
        READ_BYTE = 3'd3,
        SEND      = 3'd4,
        ECHO      = 3'd5
    } boot_state_e;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_HIGH = 3'd4
    } rx_state_e;

    // Command word for the SPI shifter, MSB-aligned in 32 bits
    function automatic logic [31:0] spi_cmd(input logic [7:0] op, input logic [23:0] addr);
        return {op, addr};
    endfunction

endpackage

// File: rtl/np_uart.sv
// 8N1 UART: transmitter with valid/ready byte input, receiver with 1-cycle valid pulse.
module np_uart
    import np_pkg::*;
#(
    parameter int CLKS_PER_BIT = 106
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       ser_tx,
    input  logic       ser_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0] TX_BIT_LAST = 4'(UART_FRAME_BITS - 1);
    localparam logic [2:0] RX_BIT_LAST = 3'(UART_DATA_BITS - 1);

    // TX state
    logic             tx_busy_q, tx_busy_d;
    logic [9:0]       tx_shift_q, tx_shift_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]       tx_bit_q, tx_bit_d;
    logic             ser_tx_q, ser_tx_d;
    logic             tx_last;

    // RX state
    logic             sync1_q, sync1_d, sync2_q, sync2_d;
    rx_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic             rx_valid_q, rx_valid_d;

    // Final cycle of the stop bit: a new byte may be accepted here so frames abut.
    assign tx_last  = tx_busy_q && (tx_bit_q == TX_BIT_LAST) && (tx_cnt_q == BIT_LAST);
    assign tx_ready = !tx_busy_q || tx_last;
    assign ser_tx   = ser_tx_q;
    assign rx_data  = rx_shift_q;
    assign rx_valid = rx_valid_q;

    // TX: shift {stop, data, start} out LSB first; ser_tx is registered, so the
    // line follows the shift register one cycle after load.
    always_comb begin
        tx_busy_d  = tx_busy_q;
        tx_shift_d = tx_shift_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        if (tx_busy_q) begin
            if (tx_cnt_q == BIT_LAST) begin
                tx_cnt_d   = '0;
                tx_shift_d = {1'b1, tx_shift_q[9:1]};
                tx_bit_d   = tx_bit_q + 4'd1;
                if (tx_bit_q == TX_BIT_LAST) tx_busy_d = 1'b0;
            end else begin
                tx_cnt_d = tx_cnt_q + CNT_W'(1);
            end
        end
        if (tx_valid && tx_ready) begin
            tx_busy_d  = 1'b1;
            tx_shift_d = {1'b1, tx_data, 1'b0};
            tx_cnt_d   = '0;
            tx_bit_d   = '0;
        end
        ser_tx_d = tx_busy_q ? tx_shift_q[0] : 1'b1;
    end

    // RX: 2-flop synchronizer, mid-bit sampling. Idle is only entered after a high
    // sample, so a low seen in idle is always a falling edge.
    always_comb begin
        sync1_d    = ser_rx;
        sync2_d    = sync1_q;
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_valid_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!sync2_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {sync2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == RX_BIT_LAST) rx_state_d = RX_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d = '0;
                    if (sync2_q) begin
                        rx_valid_d = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_WAIT_HIGH;   // framing error: drop byte
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            RX_WAIT_HIGH: begin
                if (sync2_q) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_busy_q  <= 1'b0;
            tx_shift_q <= '1;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            ser_tx_q   <= 1'b1;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            tx_busy_q  <= tx_busy_d;
            tx_shift_q <= tx_shift_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            ser_tx_q   <= ser_tx_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_valid_q <= rx_valid_d;
        end
    end

endmodule

// File: rtl/np_boot_io.sv
// Boot/IO top: wakes SPI flash, streams a boot block to UART/LEDs, then echoes UART.
module np_boot_io
    import np_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 106,
    parameter int          SPI_HALF     = 2,
    parameter logic [23:0] FLASH_BASE   = 24'h100000,
    parameter int          BOOT_LEN     = 16,
    parameter int          CS_GAP       = 8
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] leds,
    input  logic       ser_rx,
    output logic       ser_tx,
    output logic       flash_csb,
    output logic       flash_clk,
    output logic       flash_io0,
    input  logic       flash_io1,
    output logic       flash_io2,
    output logic       flash_io3
);

    localparam int DIV_W = (SPI_HALF > 1) ? $clog2(SPI_HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SPI_HALF - 1);
    localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((CS_GAP > 0) ? CS_GAP - 1 : 0);
    localparam logic [16:0] BOOT_LEN_X = 17'(BOOT_LEN);

    // Sequencer state
    boot_state_e state_q, state_d;
    logic             launched_q, launched_d;   // SPI transfer of this state issued
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [15:0]      byte_cnt_q, byte_cnt_d;
    logic [7:0]       leds_q, leds_d;
    logic             csb_q, csb_d;
    logic             hold_full_q, hold_full_d;
    logic [7:0]       hold_data_q, hold_data_d;

    // SPI shifter state
    logic             spi_active_q, spi_active_d;
    logic [DIV_W-1:0] spi_div_q, spi_div_d;
    logic             fclk_q, fclk_d;
    logic             io0_q, io0_d;
    logic [31:0]      spi_out_q, spi_out_d;
    logic [7:0]       spi_in_q, spi_in_d;
    logic [5:0]       spi_left_q, spi_left_d;

    // Sequencer -> shifter / UART
    logic        spi_start;
    logic [5:0]  spi_len;
    logic [31:0] spi_word;
    logic        tx_valid, tx_ready;
    logic [7:0]  tx_data, rx_data;
    logic        rx_valid;

    np_uart #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
        .clk      (clk),
        .reset    (reset),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .ser_tx   (ser_tx),
        .ser_rx   (ser_rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid)
    );

    assign leds      = leds_q;
    assign flash_csb = csb_q;
    assign flash_clk = fclk_q;
    assign flash_io0 = io0_q;
    assign flash_io2 = 1'b1;
    assign flash_io3 = 1'b1;

    // Boot sequencer: each SPI state launches one transfer, then waits for it to drain.
    always_comb begin
        state_d     = state_q;
        launched_d  = launched_q;
        gap_cnt_d   = gap_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        leds_d      = leds_q;
        csb_d       = csb_q;
        hold_full_d = hold_full_q;
        hold_data_d = hold_data_q;
        spi_start   = 1'b0;
        spi_len     = '0;
        spi_word    = '0;
        tx_valid    = 1'b0;
        tx_data     = hold_data_q;
        case (state_q)
            WAKE: begin
                if (!launched_q) begin
                    spi_start  = 1'b1;
                    spi_len    = 6'd8;
                    spi_word   = {OP_WAKE, 24'h0};
                    csb_d      = 1'b0;
                    launched_d = 1'b1;
                end else if (!spi_active_q) begin
                    csb_d      = 1'b1;
                    launched_d = 1'b0;
                    gap_cnt_d  = '0;
                    state_d    = GAP1;
                end
            end
            GAP1: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    state_d   = (BOOT_LEN == 0) ? ECHO : READ_CMD;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            READ_CMD: begin
                if (!launched_q) begin
                    spi_start  = 1'b1;
                    spi_len    = 6'd32;
                    spi_word   = spi_cmd(OP_READ, FLASH_BASE);
                    csb_d      = 1'b0;
                    launched_d = 1'b1;
                end else if (!spi_active_q) begin
                    launched_d = 1'b0;
                    state_d    = READ_BYTE;
                end
            end
            READ_BYTE: begin
                if (!launched_q) begin
                    spi_start  = 1'b1;
                    spi_len    = 6'd8;
                    launched_d = 1'b1;
                end else if (!spi_active_q) begin
                    launched_d = 1'b0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                // SPI stays stalled with CS low so the read continues seamlessly
                tx_valid = 1'b1;
                tx_data  = spi_in_q;
                if (tx_ready) begin
                    leds_d     = spi_in_q;
                    byte_cnt_d = byte_cnt_q + 16'd1;
                    if (({1'b0, byte_cnt_q} + 17'd1) < BOOT_LEN_X) begin
                        state_d = READ_BYTE;
                    end else begin
                        csb_d   = 1'b1;
                        state_d = ECHO;
                    end
                end
            end
            ECHO: begin
                tx_valid = hold_full_q;
                if (hold_full_q && tx_ready) begin
                    leds_d      = hold_data_q;
                    hold_full_d = 1'b0;
                end
                // A byte arriving while the holding register is full is dropped
                if (rx_valid && !hold_full_q) begin
                    hold_full_d = 1'b1;
                    hold_data_d = rx_data;
                end
            end
            default: state_d = WAKE;
        endcase
    end

    // SPI mode 0 shifter: io0 updates on falling clk, io1 captured on rising clk.
    always_comb begin
        spi_active_d = spi_active_q;
        spi_div_d    = spi_div_q;
        fclk_d       = fclk_q;
        io0_d        = io0_q;
        spi_out_d    = spi_out_q;
        spi_in_d     = spi_in_q;
        spi_left_d   = spi_left_q;
        if (spi_start) begin
            spi_active_d = 1'b1;
            spi_div_d    = '0;
            fclk_d       = 1'b0;
            io0_d        = spi_word[31];
            spi_out_d    = {spi_word[30:0], 1'b0};
            spi_left_d   = spi_len;
        end else if (spi_active_q) begin
            if (spi_div_q == DIV_LAST) begin
                spi_div_d = '0;
                if (!fclk_q) begin
                    fclk_d     = 1'b1;
                    spi_in_d   = {spi_in_q[6:0], flash_io1};
                    spi_left_d = spi_left_q - 6'd1;
                end else begin
                    fclk_d = 1'b0;
                    if (spi_left_q == 6'd0) begin
                        spi_active_d = 1'b0;
                    end else begin
                        io0_d     = spi_out_q[31];
                        spi_out_d = {spi_out_q[30:0], 1'b0};
                    end
                end
            end else begin
                spi_div_d = spi_div_q + DIV_W'(1);
            end
        end
    end

    // State registers with synchronous reset; CS and clk return idle on the reset edge
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= WAKE;
            launched_q   <= 1'b0;
            gap_cnt_q    <= '0;
            byte_cnt_q   <= '0;
            leds_q       <= 8'h00;
            csb_q        <= 1'b1;
            hold_full_q  <= 1'b0;
            hold_data_q  <= 8'h00;
            spi_active_q <= 1'b0;
            spi_div_q    <= '0;
            fclk_q       <= 1'b0;
            io0_q        <= 1'b0;
            spi_out_q    <= '0;
            spi_in_q     <= '0;
            spi_left_q   <= '0;
        end else begin
            state_q      <= state_d;
            launched_q   <= launched_d;
            gap_cnt_q    <= gap_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            leds_q       <= leds_d;
            csb_q        <= csb_d;
            hold_full_q  <= hold_full_d;
            hold_data_q  <= hold_data_d;
            spi_active_q <= spi_active_d;
            spi_div_q    <= spi_div_d;
            fclk_q       <= fclk_d;
            io0_q        <= io0_d;
            spi_out_q    <= spi_out_d;
            spi_in_q     <= spi_in_d;
            spi_left_q   <= spi_left_d;
        end
    end

endmodule

// File: tb/tb_np_boot_io.sv
// Bench for np_boot_io: behavioural SPI flash, UART decoder with scoreboard queue.
module tb_np_boot_io;

    localparam int CPB = 106;

    logic       clk, reset, ser_rx, ser_tx;
    logic [7:0] leds;
    logic       flash_csb, flash_clk, flash_io0, flash_io1, flash_io2, flash_io3;

    np_boot_io #(
        .CLKS_PER_BIT (CPB),
        .SPI_HALF     (2),
        .FLASH_BASE   (24'h100000),
        .BOOT_LEN     (16),
        .CS_GAP       (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .leds      (leds),
        .ser_rx    (ser_rx),
        .ser_tx    (ser_tx),
        .flash_csb (flash_csb),
        .flash_clk (flash_clk),
        .flash_io0 (flash_io0),
        .flash_io1 (flash_io1),
        .flash_io2 (flash_io2),
        .flash_io3 (flash_io3)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mem[0:31];

    // flash model bookkeeping
    logic [31:0] win_hdr[0:31];
    int win_rises[0:31];
    int gap_hi[0:31];
    int n_win = 0;
    int cur_rises = 0;

    // uart decoder bookkeeping
    int n_rx = 0;
    int mon_fall = 0;
    int t_stop = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #(90000 * 10);
        n_err++;
        $display("FAIL watchdog: simulation ran past cycle limit");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    // Behavioural SPI flash, evaluated on the falling system clock
    initial begin
        logic pcs, pfc;
        logic [31:0] sh;
        int hi;
        int rel;
        pcs = 1; pfc = 0; sh = 0; hi = 0;
        flash_io1 = 0;
        forever begin
            @(negedge clk);
            if (flash_csb) begin
                if (!pcs) begin
                    if (n_win < 32) win_rises[n_win] = cur_rises;
                    n_win++;
                end
                hi++;
            end else begin
                if (pcs) begin
                    if (n_win < 32) gap_hi[n_win] = hi;
                    cur_rises = 0;
                    sh = 0;
                end
                hi = 0;
                if (flash_clk && !pfc) begin
                    if (cur_rises < 32) sh = {sh[30:0], flash_io0};
                    if (n_win < 32) win_hdr[n_win] = sh;
                    cur_rises++;
                    if (cur_rises > 32 && sh[31:24] == 8'h03 && (cur_rises - 32) % 8 == 0) begin
                        rel = int'(sh[23:0]) - 32'h100000 + (cur_rises - 33) / 8;
                        exp_q.push_back((rel >= 0 && rel < 32) ? mem[rel] : 8'hFF);
                    end
                end
                if (!flash_clk && pfc && cur_rises >= 32 && sh[31:24] == 8'h03) begin
                    rel = int'(sh[23:0]) - 32'h100000 + (cur_rises - 32) / 8;
                    flash_io1 = ((rel >= 0 && rel < 32) ? mem[rel][7 - ((cur_rises - 32) % 8)] : 1'b1);
                end
            end
            pcs = flash_csb;
            pfc = flash_clk;
        end
    end

    // UART decoder: mid-bit sampling, pops and compares the scoreboard
    initial begin
        logic [7:0] b;
        logic [7:0] e;
        logic stp;
        forever begin
            @(negedge clk);
            if (ser_tx === 1'b0 && !reset) begin
                mon_fall = cyc;
                repeat (53) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = ser_tx;
                end
                repeat (CPB) @(negedge clk);
                stp = ser_tx;
                n_rx++;
                check("tx_stop_bit", {31'd0, stp}, 32'd1);
                if (exp_q.size() == 0) begin
                    check("tx_unexpected_frame", {24'd0, b}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_byte", {24'd0, b}, {24'd0, e});
                    check("leds_follow_tx", {24'd0, leds}, {24'd0, e});
                end
            end
        end
    end

    task automatic send_rx(input logic [7:0] b, input logic stp);
        logic [9:0] fr;
        fr = {stp, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            ser_rx = fr[k];
            if (k == 9) t_stop = cyc;
            repeat (CPB) @(negedge clk);
        end
        ser_rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    typedef struct {
        logic       rst;
        int         ncyc;
        logic [5:0] pins;   // csb, fclk, io0, io2, io3, ser_tx
        logic [7:0] leds;
    } vec_t;

    initial begin
        vec_t vt[6];
        string s;
        int base, rx0, bad;
        logic [9:0] fr;

        s = "Hello, NinPortable";
        for (int i = 0; i < 32; i++) mem[i] = 8'hFF;
        for (int i = 0; i < s.len(); i++) mem[i] = s[i];

        // Reset state, then the opening of the 8'hAB wake command (SPI_HALF=2)
        vt[0] = '{1'b1, 3, 6'b1_0_0_1_1_1, 8'h00};
        vt[1] = '{1'b0, 1, 6'b0_0_1_1_1_1, 8'h00};  // CS low, bit7=1 set up
        vt[2] = '{1'b0, 2, 6'b0_1_1_1_1_1, 8'h00};  // first rising clk
        vt[3] = '{1'b0, 2, 6'b0_0_0_1_1_1, 8'h00};  // falling: bit6=0
        vt[4] = '{1'b0, 2, 6'b0_1_0_1_1_1, 8'h00};  // rising, data held
        vt[5] = '{1'b0, 2, 6'b0_0_1_1_1_1, 8'h00};  // falling: bit5=1
        ser_rx = 1'b1;
        reset = 1'b1;
        for (int v = 0; v < 6; v++) begin
            reset = vt[v].rst;
            repeat (vt[v].ncyc) @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d_pins", v),
                  {26'd0, flash_csb, flash_clk, flash_io0, flash_io2, flash_io3, ser_tx},
                  {26'd0, vt[v].pins});
            check($sformatf("vec%0d_leds", v), {24'd0, leds}, {24'd0, vt[v].leds});
        end

        // Command windows
        for (int i = 0; i < 2000 && n_win < 1; i++) @(negedge clk);
        check("wake_window_closed", n_win, 1);
        check("wake_opcode", {24'd0, win_hdr[0][7:0]}, 32'hAB);
        check("wake_clocks", win_rises[0], 8);
        for (int i = 0; i < 2000 && cur_rises < 32; i++) @(negedge clk);
        check("read_cmd_addr", win_hdr[1], 32'h03100000);
        check("cs_gap_min", {31'd0, gap_hi[1] >= 8}, 32'd1);

        // Boot stream: 16 bytes from FLASH_BASE
        for (int i = 0; i < 25000 && n_rx < 16; i++) @(negedge clk);
        check("boot_frames", n_rx, 16);
        check("boot_leds_last", {24'd0, leds}, {24'd0, mem[15]});
        check("boot_queue_empty", exp_q.size(), 0);
        check("boot_cs_released", {31'd0, flash_csb}, 32'd1);
        repeat (50) @(negedge clk);

        // Echo of a valid byte
        exp_q.push_back(8'h5A);
        send_rx(8'h5A, 1'b1);
        for (int i = 0; i < 3000 && n_rx < 17; i++) @(negedge clk);
        check("echo_frame", n_rx, 17);
        check("echo_latency_ok", {31'd0, (mon_fall - t_stop) <= 2 * CPB}, 32'd1);
        check("echo_leds", {24'd0, leds}, 32'h5A);

        // Framing error: no echo, leds untouched
        rx0 = n_rx;
        send_rx(8'h33, 1'b0);
        repeat (3 * CPB) @(negedge clk);
        check("framing_no_tx", n_rx, rx0);
        check("framing_leds", {24'd0, leds}, 32'h5A);

        // Short glitch on an idle line is not a start bit
        ser_rx = 1'b0;
        repeat (20) @(negedge clk);
        ser_rx = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        check("glitch_no_tx", n_rx, rx0);

        exp_q.push_back(8'h34);
        send_rx(8'h34, 1'b1);
        for (int i = 0; i < 3000 && n_rx < rx0 + 1; i++) @(negedge clk);
        check("after_ferr_echo", n_rx, rx0 + 1);
        check("after_ferr_leds", {24'd0, leds}, 32'h34);

        // Reboot with 8'hA5 first, abort it mid READ_BYTE, then reboot again
        mem[0] = 8'hA5;
        base = n_win;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3000 && !(n_win == base + 1 && cur_rises >= 36); i++) @(negedge clk);
        check("reached_read_byte", {31'd0, n_win == base + 1 && cur_rises >= 36}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_csb", {31'd0, flash_csb}, 32'd1);
        check("abort_ser_tx", {31'd0, ser_tx}, 32'd1);
        check("abort_fclk", {31'd0, flash_clk}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3000 && n_win < base + 3; i++) @(negedge clk);
        check("restart_window", n_win, base + 3);
        check("restart_opcode", {24'd0, win_hdr[base + 2][7:0]}, 32'hAB);

        // 8'hA5 frame: every bit exactly CPB cycles, LSB first
        for (int i = 0; i < 3000 && ser_tx !== 1'b0; i++) @(negedge clk);
        check("a5_start_seen", {31'd0, ser_tx}, 32'd0);
        check("a5_leds", {24'd0, leds}, 32'hA5);
        fr = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < 10; k++) begin
            bad = 0;
            for (int c = 0; c < CPB; c++) begin
                if (ser_tx !== fr[k]) bad++;
                @(negedge clk);
            end
            check($sformatf("a5_bit%0d_bad_cycles", k), bad, 0);
        end
        check("a5_decoded", n_rx, rx0 + 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
